// File: rtl/mmcm_drp_sequencer.sv
// Run-time MMCME2_ADV reprogramming: holds the MMCM in reset, applies a queue
// of DRP read-modify-write entries, releases reset and waits for LOCKED.
module mmcm_drp_sequencer #(
  parameter int DEPTH        = 8,
  parameter int RST_HOLD     = 4,
  parameter int DRDY_TIMEOUT = 64,
  parameter int LOCK_TIMEOUT = 65535
) (
  input  logic        clkin,
  input  logic        rst,
  input  logic        cfg_wr,
  input  logic [6:0]  cfg_addr,
  input  logic [15:0] cfg_data,
  input  logic [15:0] cfg_mask,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code,
  output logic [6:0]  daddr,
  output logic [15:0] di,
  input  logic [15:0] do_in,
  output logic        den,
  output logic        dwe,
  input  logic        drdy,
  output logic        mmcm_rst,
  input  logic        mmcm_locked
);

  localparam int IW    = $clog2(DEPTH);
  localparam int CW    = IW + 1;
  localparam int TMAX0 = (DRDY_TIMEOUT > LOCK_TIMEOUT) ? DRDY_TIMEOUT : LOCK_TIMEOUT;
  localparam int TMAX  = (TMAX0 > RST_HOLD) ? TMAX0 : RST_HOLD;
  localparam int TW    = $clog2(TMAX + 1);

  localparam logic [1:0] E_DRDY = 2'd1;
  localparam logic [1:0] E_LOCK = 2'd2;
  localparam logic [1:0] E_OVF  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HOLD,
    S_RD,
    S_RD_WAIT,
    S_WR,
    S_WR_WAIT,
    S_RELEASE,
    S_LOCK
  } state_t;

  state_t state, state_next;

  logic [6:0]    addr_q [DEPTH];
  logic [15:0]   data_q [DEPTH];
  logic [15:0]   mask_q [DEPTH];

  logic [CW-1:0] count;
  logic [IW-1:0] idx;
  logic [TW-1:0] timer;
  logic [15:0]   rd_data;

  logic          push;
  logic          overflow;
  logic          clear_err;
  logic          set_err;
  logic [1:0]    err_code_set;
  logic          capture;
  logic          idx_clr;
  logic          idx_inc;
  logic          clr_queue;
  logic          full;
  logic          last;
  logic [6:0]    cur_addr;
  logic [15:0]   merged;

  assign full     = (count == CW'(DEPTH));
  assign last     = (CW'(idx) == (count - CW'(1)));
  assign cur_addr = addr_q[idx];
  assign merged   = (rd_data & mask_q[idx]) | (data_q[idx] & ~mask_q[idx]);

  always_ff @(posedge clkin) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    busy         = 1'b0;
    done         = 1'b0;
    mmcm_rst     = 1'b0;
    den          = 1'b0;
    dwe          = 1'b0;
    daddr        = '0;
    di           = '0;
    push         = 1'b0;
    overflow     = 1'b0;
    clear_err    = 1'b0;
    set_err      = 1'b0;
    err_code_set = E_OVF;
    capture      = 1'b0;
    idx_clr      = 1'b0;
    idx_inc      = 1'b0;
    clr_queue    = 1'b0;

    case (state)
      S_IDLE: begin
        // A push in the start cycle lands before HOLD reads the count.
        if (cfg_wr) begin
          if (full) begin
            overflow = 1'b1;
          end else begin
            push = 1'b1;
          end
        end
        if (start) begin
          clear_err  = 1'b1;
          state_next = S_HOLD;
        end
      end

      S_HOLD: begin
        busy     = 1'b1;
        mmcm_rst = 1'b1;
        if (timer == TW'(RST_HOLD - 1)) begin
          if (count == '0) begin
            state_next = S_RELEASE;
          end else begin
            idx_clr    = 1'b1;
            state_next = S_RD;
          end
        end
      end

      S_RD: begin
        busy       = 1'b1;
        mmcm_rst   = 1'b1;
        den        = 1'b1;
        daddr      = cur_addr;
        state_next = S_RD_WAIT;
      end

      S_RD_WAIT: begin
        busy     = 1'b1;
        mmcm_rst = 1'b1;
        daddr    = cur_addr;
        if (drdy) begin
          capture    = 1'b1;
          state_next = S_WR;
        end else if (timer == TW'(DRDY_TIMEOUT - 1)) begin
          set_err      = 1'b1;
          err_code_set = E_DRDY;
          clr_queue    = 1'b1;
          state_next   = S_IDLE;
        end
      end

      S_WR: begin
        busy       = 1'b1;
        mmcm_rst   = 1'b1;
        den        = 1'b1;
        dwe        = 1'b1;
        daddr      = cur_addr;
        di         = merged;
        state_next = S_WR_WAIT;
      end

      S_WR_WAIT: begin
        busy     = 1'b1;
        mmcm_rst = 1'b1;
        daddr    = cur_addr;
        di       = merged;
        if (drdy) begin
          if (last) begin
            state_next = S_RELEASE;
          end else begin
            idx_inc    = 1'b1;
            state_next = S_RD;
          end
        end else if (timer == TW'(DRDY_TIMEOUT - 1)) begin
          set_err      = 1'b1;
          err_code_set = E_DRDY;
          clr_queue    = 1'b1;
          state_next   = S_IDLE;
        end
      end

      S_RELEASE: begin
        busy       = 1'b1;
        state_next = S_LOCK;
      end

      S_LOCK: begin
        busy = 1'b1;
        if (mmcm_locked) begin
          done       = 1'b1;
          clr_queue  = 1'b1;
          state_next = S_IDLE;
        end else if (timer == TW'(LOCK_TIMEOUT - 1)) begin
          set_err      = 1'b1;
          err_code_set = E_LOCK;
          clr_queue    = 1'b1;
          state_next   = S_IDLE;
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // One shared counter: restarts on every state change, so it times HOLD
  // as well as the drdy and lock waits.
  always_ff @(posedge clkin) begin
    if (rst) begin
      count    <= '0;
      idx      <= '0;
      timer    <= '0;
      rd_data  <= '0;
      err      <= 1'b0;
      err_code <= 2'd0;
    end else begin
      if (state == S_IDLE || state_next != state) begin
        timer <= '0;
      end else begin
        timer <= timer + TW'(1);
      end

      if (clr_queue) begin
        count <= '0;
      end else if (push) begin
        count <= count + CW'(1);
      end

      if (idx_clr) begin
        idx <= '0;
      end else if (idx_inc) begin
        idx <= idx + IW'(1);
      end

      if (capture) begin
        rd_data <= do_in;
      end

      if (overflow || set_err) begin
        err      <= 1'b1;
        err_code <= err_code_set;
      end else if (clear_err) begin
        err      <= 1'b0;
        err_code <= 2'd0;
      end
    end
  end

  always_ff @(posedge clkin) begin
    if (push && !rst) begin
      addr_q[count[IW-1:0]] <= cfg_addr;
      data_q[count[IW-1:0]] <= cfg_data;
      mask_q[count[IW-1:0]] <= cfg_mask;
    end
  end

endmodule

// File: tb/tb_mmcm_drp_sequencer.sv
// Self-checking bench for mmcm_drp_sequencer: random DRP queues compared
// against a transaction-level model of the read-modify-write sequence.
`timescale 1ns/1ps
module tb_mmcm_drp_sequencer;

  localparam int DEPTH        = 8;
  localparam int RST_HOLD     = 4;
  localparam int DRDY_TIMEOUT = 64;
  localparam int LOCK_TIMEOUT = 100;

  typedef struct packed {
    logic [6:0]  addr;
    logic [15:0] data;
    logic [15:0] mask;
  } entry_t;

  logic        clkin = 1'b0;
  logic        rst;
  logic        cfg_wr;
  logic [6:0]  cfg_addr;
  logic [15:0] cfg_data;
  logic [15:0] cfg_mask;
  logic        start;
  logic        busy;
  logic        done;
  logic        err;
  logic [1:0]  err_code;
  logic [6:0]  daddr;
  logic [15:0] di;
  logic [15:0] do_in;
  logic        den;
  logic        dwe;
  logic        drdy;
  logic        mmcm_rst;
  logic        mmcm_locked;

  mmcm_drp_sequencer #(
    .DEPTH(DEPTH),
    .RST_HOLD(RST_HOLD),
    .DRDY_TIMEOUT(DRDY_TIMEOUT),
    .LOCK_TIMEOUT(LOCK_TIMEOUT)
  ) dut (
    .clkin(clkin),
    .rst(rst),
    .cfg_wr(cfg_wr),
    .cfg_addr(cfg_addr),
    .cfg_data(cfg_data),
    .cfg_mask(cfg_mask),
    .start(start),
    .busy(busy),
    .done(done),
    .err(err),
    .err_code(err_code),
    .daddr(daddr),
    .di(di),
    .do_in(do_in),
    .den(den),
    .dwe(dwe),
    .drdy(drdy),
    .mmcm_rst(mmcm_rst),
    .mmcm_locked(mmcm_locked)
  );

  always #5 clkin = ~clkin;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] mem [128];
  entry_t      ref_q [$];
  logic [23:0] exp_q [$];
  logic [23:0] obs_q [$];

  int   drp_lat     = 1;
  int   lock_delay  = 10;
  bit   lock_never  = 1'b0;
  int   drop_read_n = 0;

  int          pend_cnt = 0;
  bit          pend_drop = 1'b0;
  bit          pend_we = 1'b0;
  logic [6:0]  pend_addr = '0;
  logic [15:0] pend_wdata = '0;
  logic [15:0] pend_rdata = '0;
  bit          prev_den = 1'b0;
  int          rd_seen = 0;
  int          drp_viol = 0;
  bit          armed = 1'b0;
  int          rel_cnt = 0;

  int         s_busy;
  int         s_rst;
  int         s_done;
  int         s_done_at;
  bit         s_hung;
  logic [2:0] s_err_start;

  // Behavioural DRP port and MMCM lock model, acting just after each edge.
  always begin
    @(posedge clkin);
    #1;
    drdy  = 1'b0;
    do_in = 16'($urandom);
    if (rst) begin
      pend_cnt = 0;
      prev_den = 1'b0;
    end else begin
      if (den && prev_den) drp_viol++;
      prev_den = den;
      if (pend_cnt > 0) begin
        if (!den && (daddr != pend_addr || (pend_we && di != pend_wdata))) drp_viol++;
        pend_cnt--;
        if (pend_cnt == 0 && !pend_drop) begin
          drdy  = 1'b1;
          do_in = pend_rdata;
        end
      end
      if (den) begin
        pend_addr  = daddr;
        pend_we    = dwe;
        pend_wdata = di;
        pend_drop  = 1'b0;
        pend_cnt   = drp_lat;
        if (dwe) begin
          obs_q.push_back({1'b1, daddr, di});
          mem[daddr] = di;
          pend_rdata = 16'($urandom);
        end else begin
          obs_q.push_back({1'b0, daddr, mem[daddr]});
          pend_rdata = mem[daddr];
          rd_seen++;
          if (rd_seen == drop_read_n) pend_drop = 1'b1;
        end
      end
    end
    if (mmcm_rst) begin
      armed       = 1'b1;
      rel_cnt     = 0;
      mmcm_locked = 1'b0;
    end else if (armed && !lock_never) begin
      rel_cnt++;
      if (rel_cnt > lock_delay) mmcm_locked = 1'b1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic int expBusy(input int c, input int l, input int d);
    return RST_HOLD + 2 * c * (1 + l) + 1 + d;
  endfunction

  task automatic cfgModel(input int lat, input int delay, input bit never, input int drop_n);
    drp_lat     = lat;
    lock_delay  = delay;
    lock_never  = never;
    drop_read_n = drop_n;
  endtask

  task automatic pushEntry(input logic [6:0] a, input logic [15:0] d, input logic [15:0] m);
    @(negedge clkin);
    cfg_wr   = 1'b1;
    cfg_addr = a;
    cfg_data = d;
    cfg_mask = m;
    @(negedge clkin);
    cfg_wr = 1'b0;
    if (ref_q.size() < DEPTH) ref_q.push_back({a, d, m});
  endtask

  // Expected DRP traffic: each entry reads its address, then writes the
  // masked merge; later entries see earlier writes to the same address.
  task automatic buildExpected();
    logic [15:0] shadow [128];
    logic [15:0] r;
    logic [15:0] w;
    shadow = mem;
    exp_q.delete();
    foreach (ref_q[i]) begin
      r = shadow[ref_q[i].addr];
      w = (r & ref_q[i].mask) | (ref_q[i].data & ~ref_q[i].mask);
      exp_q.push_back({1'b0, ref_q[i].addr, r});
      exp_q.push_back({1'b1, ref_q[i].addr, w});
      shadow[ref_q[i].addr] = w;
    end
  endtask

  task automatic applyStimulus(input bit with_push, input entry_t e);
    if (with_push && ref_q.size() < DEPTH) ref_q.push_back(e);
    buildExpected();
    obs_q.delete();
    rd_seen  = 0;
    drp_viol = 0;
    @(negedge clkin);
    start = 1'b1;
    if (with_push) begin
      cfg_wr   = 1'b1;
      cfg_addr = e.addr;
      cfg_data = e.data;
      cfg_mask = e.mask;
    end
    @(negedge clkin);
    start     = 1'b0;
    cfg_wr    = 1'b0;
    s_busy    = 0;
    s_rst     = 0;
    s_done    = 0;
    s_done_at = 0;
    s_hung    = 1'b1;
    s_err_start = {err, err_code};
    for (int i = 1; i <= 2000; i++) begin
      if (busy) s_busy++;
      if (mmcm_rst) s_rst++;
      if (done) begin
        s_done++;
        s_done_at = i;
      end
      if (!busy) begin
        s_hung = 1'b0;
        break;
      end
      @(negedge clkin);
    end
  endtask

  task automatic checkSequence(input string tag, input bit ok, input int exp_busy,
                               input int exp_rst, input int exp_tx, input logic [2:0] exp_err);
    checkOutput({tag, "_hang"}, 32'(s_hung), 32'd0);
    checkOutput({tag, "_err_clr"}, 32'(s_err_start), 32'd0);
    checkOutput({tag, "_done_cnt"}, s_done, 32'(ok));
    if (ok) checkOutput({tag, "_latency"}, s_done_at, exp_busy);
    checkOutput({tag, "_busy_cyc"}, s_busy, exp_busy);
    checkOutput({tag, "_rst_cyc"}, s_rst, exp_rst);
    checkOutput({tag, "_end_out"}, 32'({busy, mmcm_rst, den, dwe}), 32'd0);
    checkOutput({tag, "_err"}, 32'({err, err_code}), 32'(exp_err));
    checkOutput({tag, "_drp_rules"}, drp_viol, 32'd0);
    checkOutput({tag, "_tx_cnt"}, obs_q.size(), exp_tx);
    for (int i = 0; i < exp_tx && i < obs_q.size(); i++) begin
      checkOutput($sformatf("%s_tx%0d", tag, i), 32'(obs_q[i]), 32'(exp_q[i]));
    end
    ref_q.delete();
  endtask

  task automatic abortTest();
    bit found;
    pushEntry(7'h10, 16'($urandom), 16'($urandom));
    pushEntry(7'h11, 16'($urandom), 16'($urandom));
    cfgModel(5, 3, 1'b0, 0);
    obs_q.delete();
    rd_seen = 0;
    @(negedge clkin);
    start = 1'b1;
    @(negedge clkin);
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (den && dwe) begin
        found = 1'b1;
        break;
      end
      @(negedge clkin);
    end
    checkOutput("abort_wr_seen", 32'(found), 32'd1);
    @(negedge clkin);
    rst = 1'b1;
    @(negedge clkin);
    checkOutput("abort_outputs",
                32'({busy, done, err, err_code, daddr, di, den, dwe, mmcm_rst}), 32'd0);
    rst = 1'b0;
    ref_q.delete();
    repeat (10) @(negedge clkin);
    applyStimulus(1'b0, '0);
    checkSequence("abort_empty", 1'b1, expBusy(0, 5, 3), RST_HOLD, 0, 3'b000);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int l;
    int d;
    int c;
    bit wp;
    entry_t e;
    rst         = 1'b1;
    cfg_wr      = 1'b0;
    cfg_addr    = '0;
    cfg_data    = '0;
    cfg_mask    = '0;
    start       = 1'b0;
    drdy        = 1'b0;
    do_in       = '0;
    mmcm_locked = 1'b0;
    foreach (mem[i]) mem[i] = 16'($urandom);
    $display("[TB] mmcm_drp_sequencer bench starting");
    repeat (3) @(negedge clkin);
    checkOutput("reset_outputs",
                32'({busy, done, err, err_code, daddr, di, den, dwe, mmcm_rst}), 32'd0);
    rst = 1'b0;

    mem[8] = 16'h1145;
    pushEntry(7'h08, 16'h1041, 16'h1000);
    cfgModel(1, 10, 1'b0, 0);
    applyStimulus(1'b0, '0);
    checkSequence("single", 1'b1, expBusy(1, 1, 10), RST_HOLD + 4, 2, 3'b000);
    checkOutput("single_di", 32'(obs_q[1][15:0]), 32'h1041);

    pushEntry(7'h08, 16'($urandom), 16'($urandom));
    pushEntry(7'h09, 16'($urandom), 16'($urandom));
    pushEntry(7'h14, 16'($urandom), 16'($urandom));
    d = $urandom_range(1, 20);
    cfgModel(3, d, 1'b0, 0);
    applyStimulus(1'b0, '0);
    checkSequence("three", 1'b1, expBusy(3, 3, d), RST_HOLD + 24, 6, 3'b000);

    for (int i = 0; i < DEPTH; i++) pushEntry(7'($urandom), 16'($urandom), 16'($urandom));
    checkOutput("ovf_none", 32'({err, err_code}), 32'd0);
    pushEntry(7'($urandom), 16'($urandom), 16'($urandom));
    checkOutput("ovf_err", 32'({err, err_code}), 32'b111);
    l = $urandom_range(1, 4);
    d = $urandom_range(1, 15);
    cfgModel(l, d, 1'b0, 0);
    applyStimulus(1'b0, '0);
    checkSequence("ovf_run", 1'b1, expBusy(DEPTH, l, d), RST_HOLD + 2 * DEPTH * (1 + l),
                  2 * DEPTH, 3'b000);

    for (int i = 0; i < 3; i++) pushEntry(7'($urandom), 16'($urandom), 16'($urandom));
    cfgModel(2, 5, 1'b0, 2);
    applyStimulus(1'b0, '0);
    checkSequence("drdy_to", 1'b0, RST_HOLD + 6 + 1 + DRDY_TIMEOUT,
                  RST_HOLD + 6 + 1 + DRDY_TIMEOUT, 3, 3'b101);

    pushEntry(7'h0a, 16'($urandom), 16'($urandom));
    cfgModel(1, 5, 1'b1, 0);
    applyStimulus(1'b0, '0);
    checkSequence("lock_to", 1'b0, RST_HOLD + 4 + 1 + LOCK_TIMEOUT, RST_HOLD + 4, 2, 3'b110);
    cfgModel(1, 5, 1'b0, 0);
    applyStimulus(1'b0, '0);
    checkSequence("lock_rerun", 1'b1, expBusy(0, 1, 5), RST_HOLD, 0, 3'b000);

    abortTest();

    for (int it = 0; it < 6; it++) begin
      c  = $urandom_range(1, DEPTH - 1);
      wp = it[0];
      for (int k = 0; k < c; k++) pushEntry(7'($urandom_range(0, 7)), 16'($urandom), 16'($urandom));
      e.addr = 7'($urandom_range(0, 7));
      e.data = 16'($urandom);
      e.mask = 16'($urandom);
      l = $urandom_range(1, 4);
      d = $urandom_range(1, 15);
      cfgModel(l, d, 1'b0, 0);
      applyStimulus(wp, e);
      c = c + int'(wp);
      checkSequence($sformatf("rand%0d", it), 1'b1, expBusy(c, l, d),
                    RST_HOLD + 2 * c * (1 + l), 2 * c, 3'b000);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mmcm_drp_sequencer.md
Name: mmcm_drp_sequencer

Overview:
- Reprograms the on-chip sensor clock generator (MMCME2_ADV) at run time through its DRP port. Typical uses: changing CLKOUTn divide or phase, or CLKFBOUT_MULT.
- Host logic loads a small queue of (address, data, mask) DRP entries, then pulses start.
- The block then holds the MMCM in reset, applies each entry as a read-modify-write, releases reset and waits for LOCKED.
- Sits beside the clock block in the static clock domain (clkin, 100 MHz); owns the MMCM RST, DRP and LOCKED pins.

Parameters:
- DEPTH, 8, number of queue entries (power of two, 2..16).
- RST_HOLD, 4, cycles mmcm_rst is held high before the first DRP access.
- DRDY_TIMEOUT, 64, maximum cycles to wait for drdy after any den pulse.
- LOCK_TIMEOUT, 65535, maximum cycles to wait for mmcm_locked after reset release.

Ports:
- clkin  in  1  DRP/controller clock (same clock as MMCM DCLK)
- rst  in  1  synchronous, active-high reset
- cfg_wr  in  1  push one entry into queue
- cfg_addr  in  7  DRP address of entry
- cfg_data  in  16  new bit values of entry
- cfg_mask  in  16  1 = keep current bit, 0 = take cfg_data bit
- start  in  1  begin reconfiguration sequence
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse on successful relock
- err  out  1  sticky error flag
- err_code  out  2  0 none, 1 drdy timeout, 2 lock timeout, 3 queue overflow
- daddr  out  7  DRP address
- di  out  16  DRP write data
- do_in  in  16  DRP read data
- den  out  1  DRP enable
- dwe  out  1  DRP write enable
- drdy  in  1  DRP ready
- mmcm_rst  out  1  MMCM RST
- mmcm_locked  in  1  MMCM LOCKED

Behaviour:
- Clock and reset are fixed: one clock; reset is synchronous and active-high.
- Reset values: all outputs 0, queue count 0, FSM in IDLE.
  - rst during a sequence aborts it and drops mmcm_rst to 0 on the next edge.
  - The MMCM may then be left partially programmed; software must re-run the sequence.
- Queue:
  - cfg_wr is accepted only in IDLE.
  - An entry is stored at index count, and count increments.
  - cfg_wr while count == DEPTH: entry dropped, err=1, err_code=3.
  - cfg_wr while busy is ignored and raises no error.
- start:
  - Sampled only in IDLE; clears err/err_code.
  - start and cfg_wr in the same cycle: the entry is pushed first, then the sequence starts including it.
- FSM states:
  - IDLE: on start, go to HOLD with mmcm_rst=1 and busy=1 from the next cycle.
  - HOLD: count RST_HOLD cycles. If queue is empty go to RELEASE, else set idx=0 and go to RD.
  - RD: den=1 for exactly one cycle, daddr=entry[idx].addr, dwe=0; go to RD_WAIT.
  - RD_WAIT: on drdy, capture do_in; go to WR.
  - WR: den=1, dwe=1 for one cycle, daddr=entry[idx].addr, di=(captured & mask) | (data & ~mask); go to WR_WAIT.
  - WR_WAIT: on drdy, if idx == count-1 go to RELEASE, else idx++ and go to RD.
  - RELEASE: mmcm_rst=0; go to LOCK.
  - LOCK: when mmcm_locked=1, pulse done, clear queue (count=0), busy=0, go to IDLE.
- DRP rules:
  - den/dwe are never high in two consecutive cycles.
  - daddr/di hold stable from the den cycle until drdy.
  - drdy seen in any state other than RD_WAIT or WR_WAIT is ignored.
- Timeouts:
  - Timeout counter restarts on entry to RD_WAIT, WR_WAIT and LOCK.
  - drdy timeout: the DRDY_TIMEOUT-th wait cycle without drdy → err=1, err_code=1, mmcm_rst=0, queue cleared, IDLE, no done pulse.
  - lock timeout: LOCK_TIMEOUT cycles without locked → err=1, err_code=2, IDLE, queue cleared.
- Latency, with drdy returning 1 cycle after den: start→done = 1 + RST_HOLD + 4·count + 1 + lock wait cycles.

Test Plan:
- Single entry: push addr 0x08, data 0x1041, mask 0x1000; DRP model returns 0x1145 → exactly one read then one write with di=0x1041; mmcm_rst high ≥4 cycles; locked asserted 10 cycles after release → done pulse, busy low, count 0.
- Three entries (0x08, 0x09, 0x14), drdy latency 3 → reads/writes strictly in push order, no back-to-back den, done exactly once.
- Overflow: 9 pushes with DEPTH=8 → err=1, err_code=3; start then runs only the 8 stored entries.
- DRP model never returns drdy on second read → after 64 wait cycles err_code=1, mmcm_rst=0, no done, busy=0.
- mmcm_locked held 0 with LOCK_TIMEOUT=100 → err_code=2 at cycle 100 after release; a following start clears err.
- rst asserted during WR_WAIT → next cycle all outputs 0, IDLE, count 0; empty-queue start → HOLD, RELEASE, done, with no den pulse.
